i2c_legacy_target: RTL
======================

// Module: i2c_legacy_target
// PURPOSE
//  Open-drain I2C target that answers on the SoC's I3C bus pins, acting as the far end of the SoC I3C controller.
//  It sits in the FPGA top level beside the SoC and gives bring-up firmware a known device to address.
//  It implements legacy I2C private writes and reads into a small register file.
//  The register file is mirrored to the top level for LEDs and debug.
// PARAMETERS
//  TARGET_ADDR  7'h50  7-bit static address that the block ACKs
//  NUM_REGS     16     register file depth in bytes; must be a power of two, 2..256
//  SYNC_STAGES  2      synchroniser flops on scl_i and sda_i; minimum 2
// PORTS
//  clk_i        in   1                   system clock; must be at least 10x the SCL frequency
//  rst_i        in   1                   asynchronous, active-high reset
//  scl_i        in   1                   SCL pad input, asynchronous
//  sda_i        in   1                   SDA pad input, asynchronous
//  sda_o        out  1                   SDA output value; constant 0 (open drain)
//  sda_oe       out  1                   1 = pull SDA low
//  busy_o       out  1                   1 while addressed, from address ACK until STOP or repeated START
//  wr_pulse_o   out  1                   1-cycle strobe for each data byte committed to the register file
//  wr_idx_o     out  $clog2(NUM_REGS)    register index of the committed byte
//  wr_data_o    out  8                   value of the committed byte
//  rd_idx_i     in   $clog2(NUM_REGS)    debug read index
//  rd_data_o    out  8                   regs[rd_idx_i]; combinational
// BEHAVIOUR
//  Reset: sda_oe=0, busy_o=0, wr_pulse_o=0, wr_idx_o=0, wr_data_o=0, regs=0, ptr=0, state=IDLE.
//   Reset is asynchronous, so the bus is released immediately, including mid-transfer.
//  Pin sync: scl/sda pass through SYNC_STAGES flops. Edges are found from the last two synchronised samples.
//   START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in every state.
//   Every other event is an SCL rise (sample) or an SCL fall (drive).
//  Latency: sda_oe updates on the clk_i cycle after the synchronised SCL fall, i.e. SYNC_STAGES+1 cycles after the pin edge.
//  States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
//   START or repeated START, from any state -> ADDR with bit count 0.
//   STOP, from any state -> IDLE; sda_oe=0 and busy_o=0 in the same cycle.
//   ADDR: shift SDA MSB-first on SCL rise, 8 bits. At the 8th rise, compare byte[7:1] with TARGET_ADDR.
//    Match -> ADDR_ACK and latch rw=byte[0]. Mismatch -> WAIT_STOP.
//   ADDR_ACK: on SCL fall set sda_oe=1 and busy_o=1. On the next SCL fall:
//    rw=0 -> WR_BYTE with sda_oe=0.
//    rw=1 -> RD_BYTE; load shreg=regs[ptr] and drive its bit 7 (sda_oe = ~bit).
//   WR_BYTE: shift 8 bits, then -> WR_ACK.
//    First byte after the address is the pointer: ptr = byte[$clog2(NUM_REGS)-1:0], upper bits ignored.
//    Later bytes: regs[ptr]=byte, wr_pulse_o for 1 cycle, then ptr = ptr+1 with wrap NUM_REGS-1 -> 0.
//   WR_ACK: ACK on SCL fall (sda_oe=1). Release on the following SCL fall and return to WR_BYTE. Every byte is ACKed.
//   RD_BYTE: drive the next bit on each SCL fall. After the 8th bit, release SDA on SCL fall and go to RD_ACK.
//   RD_ACK: sample the controller's bit on SCL rise.
//    0 (ACK): ptr = ptr+1 with wrap; reload shreg from regs[ptr] and return to RD_BYTE.
//    1 (NACK): -> WAIT_STOP with SDA released.
//   WAIT_STOP: ignore SCL and keep sda_oe=0 until START or STOP.
//  Pointer persistence: ptr survives STOP, so a read without a pointer byte continues from the last ptr.
//  Simultaneous events: a START/STOP in the same cycle as an SCL edge wins; the SCL edge is dropped.
//   SCL and SDA changing in the same sync sample is a protocol violation: treat it as an SCL edge only.
//  sda_oe never changes while synchronised SCL is high, except release on STOP or reset.
// STRUCTURE
//  Package i2c_target_pkg: state enum (state_e), ACK=1'b0, NACK=1'b1.
//  Sub-module i2c_bus_monitor: synchronisers plus edge detection.
//   Outputs 1-cycle pulses scl_rise, scl_fall, start_det, stop_det, and the synchronised sda.
//  The top of this block holds the FSM, shift register, bit counter, ptr and the register file (flops).
// TESTING
//  1. Write 0x50<<1|0, ptr 0x03, data 0xA5, 0x3C, STOP.
//     -> both bytes and the address are ACKed; wr_pulse_o at idx 3 then 4; rd_data_o(3)=0xA5, rd_data_o(4)=0x3C.
//  2. Write ptr 0x03, repeated START, read 2 bytes (ACK then NACK), STOP.
//     -> controller samples 0xA5 then 0x3C; SDA released after the NACK; busy_o falls at STOP.
//  3. Address 0x51 write.
//     -> no ACK (sda_oe stays 0 for the whole transfer); no wr_pulse_o; state WAIT_STOP until STOP.
//  4. NUM_REGS=16: ptr 0x1F, write 0x11, 0x22.
//     -> regs[15]=0x11, regs[0]=0x22 (wrap); pointer upper bits ignored.
//  5. rst_i asserted while driving bit 7 of a read byte = 0.
//     -> sda_oe=0 with no clock edge; after deassert, the next START with the matching address is ACKed normally.
//  6. STOP injected mid-byte during WR_BYTE.
//     -> IDLE; the partial byte is not written; no wr_pulse_o.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types for the legacy I2C target: FSM state encoding and ACK/NACK bit levels.
// No logic here; no latency or backpressure.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA pads and emits 1-cycle scl_rise/scl_fall/start_det/stop_det pulses.
// Pulses appear SYNC_STAGES cycles after a pin edge; no backpressure, the bus cannot be stalled.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   scl_held_high;

  // Flops reset to 1 so an idle (pulled-up) bus shows no edges out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda   = sda_sync[SYNC_STAGES-1];

  // SDA moving in the same sample as SCL is treated as an SCL edge only.
  assign scl_held_high = scl_s & scl_prev;
  assign scl_rise      = scl_s & ~scl_prev;
  assign scl_fall      = ~scl_s & scl_prev;
  assign start_det     = scl_held_high & sda_prev & ~sda;
  assign stop_det      = scl_held_high & ~sda_prev & sda;

endmodule

// File: rtl/i2c_legacy_target.sv
// Open-drain I2C target with a small byte register file supporting pointer-addressed writes and reads.
// sda_oe moves SYNC_STAGES+1 clk_i cycles after an SCL fall pin edge; the target never stretches SCL.
module i2c_legacy_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        sda_oe,
  output logic                        busy_o,
  output logic                        wr_pulse_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
  output logic [7:0]                  wr_data_o,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx_i,
  output logic [7:0]                  rd_data_o
);

  localparam int              PW      = $clog2(NUM_REGS);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic          first_q, first_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    rx_byte;
  logic          wr_en;

  assign rx_byte = {shreg_q[6:0], sda};
  assign ptr_inc = ptr_q + PTR_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    rw_d    = rw_q;
    first_d = first_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            rw_d    = sda;
            state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
          end
        end
        // oe_q doubles as the phase flag: first fall drives ACK, second fall leaves.
        ADDR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d   = 1'b1;
            busy_d = 1'b1;
          end else if (!rw_q) begin
            state_d = WR_BYTE;
            oe_d    = 1'b0;
            first_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = RD_BYTE;
            shreg_d = {regs_q[ptr_q][6:0], 1'b0};
            oe_d    = ~regs_q[ptr_q][7];
            cnt_d   = 4'd1;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = WR_ACK;
            cnt_d   = '0;
            first_d = 1'b0;
            if (first_q) begin
              ptr_d = rx_byte[PW-1:0];
            end else begin
              wr_en = 1'b1;
              ptr_d = ptr_inc;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = WR_BYTE;
            cnt_d   = '0;
          end
        end
        // cnt counts bits already put on the bus; 8 means the byte is done.
        RD_BYTE: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = RD_ACK;
          end else begin
            oe_d    = ~shreg_q[7];
            shreg_d = {shreg_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          case (sda)
            ACK: begin
              ptr_d   = ptr_inc;
              shreg_d = regs_q[ptr_inc];
              cnt_d   = '0;
              state_d = RD_BYTE;
            end
            NACK: state_d = WAIT_STOP;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      wr_pulse_o <= 1'b0;
      wr_idx_o   <= '0;
      wr_data_o  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      wr_pulse_o <= wr_en;
      if (wr_en) begin
        wr_idx_o  <= ptr_q;
        wr_data_o <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oe    = oe_q;
  assign busy_o    = busy_q;
  assign rd_data_o = regs_q[rd_idx_i];

endmodule
